// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and widths for the pong game-flow sequencer
package pong_pkg;

  typedef enum logic [1:0] {
    ATTRACT,
    SERVE,
    PLAY
  } state_t;

  localparam int SCORE_W  = 4;
  localparam int CREDIT_W = 4;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-bit rising-edge detector with a registered previous level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/pong_game_sequencer.sv
// rtl/pong_game_sequencer.sv - credits, attract/serve/play sequencing and scores for pong
// Optional feature macro: FREE_PLAY_EN (start always accepted, coins ignored, credits held at 0).
module pong_game_sequencer
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 11,
  parameter int MAX_CREDITS  = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                coin,
  input  logic                start,
  input  logic                miss_left,
  input  logic                miss_right,
  output logic                attract,
  output logic                serve_hold,
  output logic                serve_dir,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic [CREDIT_W-1:0] credits,
  output logic                score_pulse
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0]  WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W + 1)'(MAX_CREDITS);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [SCORE_W-1:0]   score_l_n, score_r_n;
  logic [CREDIT_W-1:0]  credits_n;
  logic                 dir_n, pulse_n;
  logic                 start_rise;
  logic                 credit_ok, accept;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .level (start),
    .rise  (start_rise)
  );

`ifndef FREE_PLAY_EN
  logic                coin_rise;
  logic [CREDIT_W:0]   credit_sum;

  rise_detect u_coin_rise (
    .clk   (clk),
    .reset (reset),
    .level (coin),
    .rise  (coin_rise)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ATTRACT;
      cnt         <= '0;
      score_l     <= '0;
      score_r     <= '0;
      serve_dir   <= 1'b0;
      credits     <= '0;
      score_pulse <= 1'b0;
      attract     <= 1'b1;
      serve_hold  <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      serve_dir   <= dir_n;
      credits     <= credits_n;
      score_pulse <= pulse_n;
      attract     <= (state_n == ATTRACT);
      serve_hold  <= (state_n != PLAY);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    score_l_n = score_l;
    score_r_n = score_r;
    dir_n     = serve_dir;
    pulse_n   = 1'b0;
    accept    = 1'b0;
`ifdef FREE_PLAY_EN
    credit_ok = 1'b1;
`else
    credit_ok = (credits != '0);
`endif

    case (state)
      ATTRACT: begin
        if (start_rise && credit_ok) begin
          accept    = 1'b1;
          score_l_n = '0;
          score_r_n = '0;
          dir_n     = 1'b1;
          cnt_n     = '0;
          state_n   = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == CNT_LAST) state_n = PLAY;
          else                 cnt_n   = cnt + 1'b1;
        end
      end
      PLAY: begin
        // miss_left has priority; a simultaneous miss_right is dropped
        if (miss_left) begin
          score_r_n = score_r + 1'b1;
          dir_n     = 1'b0;
          pulse_n   = 1'b1;
          cnt_n     = '0;
          state_n   = (score_r_n == WIN) ? ATTRACT : SERVE;
        end else if (miss_right) begin
          score_l_n = score_l + 1'b1;
          dir_n     = 1'b1;
          pulse_n   = 1'b1;
          cnt_n     = '0;
          state_n   = (score_l_n == WIN) ? ATTRACT : SERVE;
        end
      end
      default: state_n = ATTRACT;
    endcase

`ifdef FREE_PLAY_EN
    credits_n = '0;
`else
    // accept implies credits > 0, so the net sum never underflows
    credit_sum = {1'b0, credits} + {{CREDIT_W{1'b0}}, coin_rise} - {{CREDIT_W{1'b0}}, accept};
    credits_n  = (credit_sum > MAX_C) ? MAX_C[CREDIT_W-1:0] : credit_sum[CREDIT_W-1:0];
`endif
  end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Synchronous game-flow controller for the Pong playfield logic: it owns credits, the attract/play mode, the serve-delay hold and both 4-bit scores, and sequences the gate-level ball and score datapath built from the TTL models. It replaces the latch-and-555 serve/attract circuitry with one clocked state machine. It sits between the coin/start inputs, the ball-edge miss detectors and the score display, blanking and sound logic.

## Interface
- SERVE_FRAMES, 60, frames the ball is held before each serve (≥2)
- WIN_SCORE, 11, score that ends the game (1..15)
- MAX_CREDITS, 9, credit saturation value (1..15)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame (start of vblank)
- coin  in  1  coin switch level, already synchronised to clk
- start  in  1  start button level, already synchronised to clk
- miss_left  in  1  one-cycle pulse: ball left the playfield past the left paddle
- miss_right  in  1  one-cycle pulse: ball left the playfield past the right paddle
- attract  out  1  high while no game is in progress
- serve_hold  out  1  high while the ball must be held and blanked
- serve_dir  out  1  direction of the next serve: 0 = toward left player, 1 = toward right player
- score_l  out  4  left player score
- score_r  out  4  right player score
- credits  out  4  current credit count
- score_pulse  out  1  one-cycle pulse when either score increments (sound trigger)

## Operation
- coin and start are rising-edge detected (level & ~previous level); the previous-level registers reset to 0.
- States: ATTRACT, SERVE, PLAY.
- ATTRACT: attract=1, serve_hold=1; scores from the last game stay visible. On a start edge with credits>0 (registered value): credits decrement, scores clear to 0, serve_dir set to 1, hold counter clears, next state SERVE. With credits=0, start is ignored.
- SERVE: attract=0, serve_hold=1. The counter advances on each frame_tick. On the frame_tick at which the counter equals SERVE_FRAMES-1, the next state is PLAY. Miss pulses are ignored.
- PLAY: attract=0, serve_hold=0. On miss_left: score_r increments, serve_dir becomes 0, score_pulse fires. On miss_right: score_l increments, serve_dir becomes 1, score_pulse fires. If the new score equals WIN_SCORE, the next state is ATTRACT. Otherwise the next state is SERVE and the counter clears.
- When miss_left and miss_right occur in the same cycle, miss_left wins and miss_right is dropped.
- A coin edge in any state increments credits, saturating at MAX_CREDITS.
- If a coin edge and a start edge occur in the same cycle, the start check uses the registered credits. The net update is +1 for the coin and -1 if the start is accepted. Saturation is applied to the net result.
- Scores never exceed WIN_SCORE, so no wrap is possible.
- Counter width is $clog2(SERVE_FRAMES).

## Timing
- Reset values: attract=1, serve_hold=1, serve_dir=0, score_l=0, score_r=0, credits=0, score_pulse=0, state ATTRACT, counter 0.
- Reset mid-game takes effect on the next edge and discards all game state, including credits.
- All outputs are registered. Each output changes on the clock edge after the triggering input cycle, giving 1-cycle latency.
- score_pulse is high in the same cycle as the updated score value and is exactly 1 cycle wide.
- The serve hold lasts exactly SERVE_FRAMES frame_ticks after entry to SERVE. serve_hold falls in the cycle after the last counted tick.

## Configuration
- Macro FREE_PLAY_EN.
- Defined: the credit check is bypassed and a start edge in ATTRACT always begins a game. Coin edges are ignored and credits stays 0.
- Undefined: credit behaviour exactly as in Operation.

## Structure
- Shared package pong_pkg holds:
  - the state enum (ATTRACT, SERVE, PLAY)
  - the score width constant (4)
  - the credit width constant (4)
- One sub-module, rise_detect: a single-bit registered edge detector with synchronous reset, instanced for coin and start.
- Everything else stays in pong_game_sequencer.

## Test plan
- Reset, then 2 coin edges, then 1 start edge -> credits 0→2→1; attract falls 1 cycle after the start edge; serve_hold stays 1 for exactly 60 frame_ticks; serve_dir=1.
- In PLAY, pulse miss_right 3 times with SERVE waits between -> score_l=3, score_r=0, three 1-cycle score_pulse; serve_dir=1; SERVE re-entered after each pulse.
- Drive score_r to 10, then pulse miss_left -> score_r=11, attract=1 on the next cycle; a further miss_left does not change the scores.
- 12 coin edges from reset -> credits saturates at 9; coin and start in the same cycle with credits=9 -> credits=9 and the game starts.
- miss_left and miss_right in the same cycle during PLAY -> only score_r increments and serve_dir=0. Assert reset mid-SERVE -> all outputs return to reset values on the next edge.
- With FREE_PLAY_EN defined, a start edge with credits=0 starts the game; coin edges leave credits at 0.
